// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry {pc, inst} FIFO feeding a registered RV32I decoded-packet stage.
// Optional build macro DEC_ILLEGAL_EN adds the out_illegal flag for malformed encodings.
`ifndef NOP
`define NOP    6'd0
`define LUI    6'd1
`define AUIPC  6'd2
`define JAL    6'd3
`define JALR   6'd4
`define BEQ    6'd5
`define BNE    6'd6
`define BLT    6'd7
`define BGE    6'd8
`define BLTU   6'd9
`define BGEU   6'd10
`define LB     6'd11
`define LH     6'd12
`define LW     6'd13
`define LBU    6'd14
`define LHU    6'd15
`define SB     6'd16
`define SH     6'd17
`define SW     6'd18
`define ADDI   6'd19
`define SLTI   6'd20
`define SLTIU  6'd21
`define XORI   6'd22
`define ORI    6'd23
`define ANDI   6'd24
`define SLLI   6'd25
`define SRLI   6'd26
`define SRAI   6'd27
`define ADD    6'd28
`define SUB    6'd29
`define SLL    6'd30
`define SLT    6'd31
`define SLTU   6'd32
`define XOR    6'd33
`define SRL    6'd34
`define SRA    6'd35
`define OR     6'd36
`define AND    6'd37
`endif

module decode_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [5:0]  out_optype,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [4:0]  out_rd,
   output logic [31:0] out_imm,
   output logic [31:0] out_pc
`ifdef DEC_ILLEGAL_EN
   ,
   output logic        out_illegal
`endif
);

   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_LD    = 7'b0000011;
   localparam logic [6:0] OPC_ST    = 7'b0100011;
   localparam logic [6:0] OPC_OPI   = 7'b0010011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

   logic [31:0]    q_inst [DEPTH];
   logic [31:0]    q_pc   [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [PTR_W:0] count;

   logic        push, pop, out_free;
   logic [31:0] hd_inst, hd_pc;
   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   logic [5:0]  d_op;
   logic [4:0]  d_rs1, d_rs2, d_rd;
   logic [31:0] d_imm;
   logic        d_ill;

   assign in_ready = (count < CNT_FULL);
   assign out_free = !out_valid || out_ready;
   assign push     = in_valid && in_ready;
   assign pop      = out_free && (count != '0);

   assign hd_inst = q_inst[head];
   assign hd_pc   = q_pc[head];
   assign opc     = hd_inst[6:0];
   assign f3      = hd_inst[14:12];
   assign f7      = hd_inst[31:25];

   assign imm_i = {{20{hd_inst[31]}}, hd_inst[31:20]};
   assign imm_s = {{20{hd_inst[31]}}, hd_inst[31:25], hd_inst[11:7]};
   assign imm_b = {{20{hd_inst[31]}}, hd_inst[7], hd_inst[30:25], hd_inst[11:8], 1'b0};
   assign imm_u = {hd_inst[31:12], 12'b0};
   assign imm_j = {{12{hd_inst[31]}}, hd_inst[19:12], hd_inst[20], hd_inst[30:21], 1'b0};

   // Illegal cases only raise d_ill; the final override turns them into NOP in both builds.
   always_comb begin
      d_op  = `NOP;
      d_rd  = hd_inst[11:7];
      d_rs1 = hd_inst[19:15];
      d_rs2 = '0;
      d_imm = '0;
      d_ill = 1'b0;
      case (opc)
         OPC_LUI:   begin d_op = `LUI;   d_rs1 = '0; d_imm = imm_u; end
         OPC_AUIPC: begin d_op = `AUIPC; d_rs1 = '0; d_imm = imm_u; end
         OPC_JAL:   begin d_op = `JAL;   d_rs1 = '0; d_imm = imm_j; end
         OPC_JALR: begin
            d_op  = `JALR;
            d_imm = imm_i;
            d_ill = (f3 != 3'b000);
         end
         OPC_BR: begin
            d_rd  = '0;
            d_rs2 = hd_inst[24:20];
            d_imm = imm_b;
            case (f3)
               3'b000:  d_op = `BEQ;
               3'b001:  d_op = `BNE;
               3'b100:  d_op = `BLT;
               3'b101:  d_op = `BGE;
               3'b110:  d_op = `BLTU;
               3'b111:  d_op = `BGEU;
               default: d_ill = 1'b1;
            endcase
         end
         OPC_LD: begin
            d_imm = imm_i;
            case (f3)
               3'b000:  d_op = `LB;
               3'b001:  d_op = `LH;
               3'b010:  d_op = `LW;
               3'b100:  d_op = `LBU;
               3'b101:  d_op = `LHU;
               default: d_ill = 1'b1;
            endcase
         end
         OPC_ST: begin
            d_rd  = '0;
            d_rs2 = hd_inst[24:20];
            d_imm = imm_s;
            case (f3)
               3'b000:  d_op = `SB;
               3'b001:  d_op = `SH;
               3'b010:  d_op = `SW;
               default: d_ill = 1'b1;
            endcase
         end
         OPC_OPI: begin
            d_imm = imm_i;
            case (f3)
               3'b000: d_op = `ADDI;
               3'b010: d_op = `SLTI;
               3'b011: d_op = `SLTIU;
               3'b100: d_op = `XORI;
               3'b110: d_op = `ORI;
               3'b111: d_op = `ANDI;
               3'b001: begin d_op = `SLLI; d_ill = (f7 != 7'h00); end
               default: begin
                  if (f7 == 7'h00)      d_op = `SRLI;
                  else if (f7 == 7'h20) d_op = `SRAI;
                  else                  d_ill = 1'b1;
               end
            endcase
         end
         OPC_OP: begin
            d_rs2 = hd_inst[24:20];
            if (f7 == 7'h00) begin
               case (f3)
                  3'b000:  d_op = `ADD;
                  3'b001:  d_op = `SLL;
                  3'b010:  d_op = `SLT;
                  3'b011:  d_op = `SLTU;
                  3'b100:  d_op = `XOR;
                  3'b101:  d_op = `SRL;
                  3'b110:  d_op = `OR;
                  default: d_op = `AND;
               endcase
            end else if (f7 == 7'h20 && f3 == 3'b000) begin
               d_op = `SUB;
            end else if (f7 == 7'h20 && f3 == 3'b101) begin
               d_op = `SRA;
            end else begin
               d_ill = 1'b1;
            end
         end
         default: d_ill = 1'b1;
      endcase
      if (d_ill) d_op = `NOP;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in || flush) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         out_valid  <= 1'b0;
         out_optype <= `NOP;
         out_rs1    <= '0;
         out_rs2    <= '0;
         out_rd     <= '0;
         out_imm    <= '0;
         out_pc     <= '0;
`ifdef DEC_ILLEGAL_EN
         out_illegal <= 1'b0;
`endif
      end else begin
         if (push) begin
            q_inst[tail] <= in_inst;
            q_pc[tail]   <= in_pc;
            tail         <= tail + PTR_W'(1);
         end
         if (pop) begin
            head       <= head + PTR_W'(1);
            out_valid  <= 1'b1;
            out_optype <= d_op;
            out_rs1    <= d_rs1;
            out_rs2    <= d_rs2;
            out_rd     <= d_rd;
            out_imm    <= d_imm;
            out_pc     <= hd_pc;
`ifdef DEC_ILLEGAL_EN
            out_illegal <= d_ill;
`endif
         end else if (out_free) begin
            out_valid <= 1'b0;
         end
         if (push && !pop)      count <= count + (PTR_W+1)'(1);
         else if (!push && pop) count <= count - (PTR_W+1)'(1);
      end
   end

endmodule
